// File: rtl/audio_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_serial_tx_if
// Brief    : Sample-input and serial-output bundle for audio_serial_tx.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_serial_tx_if;
  logic [17:0] l_audio_in;
  logic [17:0] r_audio_in;
  logic        ready;
  logic        sclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;
  logic        underrun;
  logic        overrun;

  modport master (
    output l_audio_in, r_audio_in, ready,
    input  sclk, lrclk, sdata, frame_start, underrun, overrun
  );

  modport slave (
    input  l_audio_in, r_audio_in, ready,
    output sclk, lrclk, sdata, frame_start, underrun, overrun
  );
endinterface
`default_nettype wire

// File: rtl/audio_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_serial_tx
// Brief    : Left-justified stereo serialiser with a one-pair holding register.
// Revision : 1.0 - initial release
// ============================================================================
module audio_serial_tx #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic             clock,
  input  logic             reset,
  audio_serial_tx_if.slave bus
);

  localparam int c_FRAME_BITS = 2 * SLOT_BITS;
  localparam int c_DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_IDX_W      = $clog2(c_FRAME_BITS);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(c_FRAME_BITS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_RIGHT = c_IDX_W'(SLOT_BITS);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

  logic [c_DIV_W-1:0]      r_div;
  logic [c_IDX_W-1:0]      r_bit_idx;
  logic                    r_sclk;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic                    r_frame_start;
  logic                    r_underrun;
  logic                    r_overrun;
  logic [17:0]             r_hold_l;
  logic [17:0]             r_hold_r;
  logic                    r_full;
  logic [c_FRAME_BITS-1:0] r_shift;

  logic                    w_toggle;
  logic                    w_tick;
  logic                    w_boundary;
  logic                    w_load;
  logic [c_IDX_W-1:0]      w_idx_next;
  logic [SLOT_BITS-1:0]    w_slot_l;
  logic [SLOT_BITS-1:0]    w_slot_r;
  logic [c_FRAME_BITS-1:0] w_frame;
  logic [c_FRAME_BITS-1:0] w_shift_src;

  always_comb begin
    w_toggle    = (r_div == c_DIV_LAST);
    // Only the falling sclk edge advances the bit stream.
    w_tick      = w_toggle && r_sclk;
    w_boundary  = (r_bit_idx == c_IDX_LAST);
    w_load      = w_tick && w_boundary;
    w_idx_next  = w_boundary ? '0 : r_bit_idx + c_IDX_ONE;
    w_slot_l    = SLOT_BITS'(r_hold_l) << (SLOT_BITS - 18);
    w_slot_r    = SLOT_BITS'(r_hold_r) << (SLOT_BITS - 18);
    w_frame     = r_full ? {w_slot_l, w_slot_r} : '0;
    w_shift_src = w_boundary ? w_frame : r_shift;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_div         <= '0;
      r_bit_idx     <= c_IDX_LAST;
      r_sclk        <= 1'b0;
      r_lrclk       <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_overrun     <= 1'b0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_full        <= 1'b0;
      r_shift       <= '0;
    end else begin
      r_frame_start <= w_load;
      r_underrun    <= w_load && !r_full;
      // A ready landing on the load edge refills a freshly emptied register.
      r_overrun     <= bus.ready && r_full && !w_load;
      r_div         <= w_toggle ? '0 : r_div + c_DIV_ONE;

      if (w_toggle) begin
        r_sclk <= !r_sclk;
      end

      if (w_tick) begin
        r_bit_idx <= w_idx_next;
        r_lrclk   <= (w_idx_next >= c_IDX_RIGHT);
        r_sdata   <= w_shift_src[c_FRAME_BITS-1];
        r_shift   <= {w_shift_src[c_FRAME_BITS-2:0], 1'b0};
      end

      if (bus.ready) begin
        r_hold_l <= bus.l_audio_in;
        r_hold_r <= bus.r_audio_in;
        r_full   <= 1'b1;
      end else if (w_load) begin
        r_full   <= 1'b0;
      end
    end
  end

  assign bus.sclk        = r_sclk;
  assign bus.lrclk       = r_lrclk;
  assign bus.sdata       = r_sdata;
  assign bus.frame_start = r_frame_start;
  assign bus.underrun    = r_underrun;
  assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_serial_tx
// Brief    : Frame-level scoreboard bench for audio_serial_tx (CLK_DIV=2, SLOT_BITS=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_serial_tx;

  localparam int CLK_DIV      = 2;
  localparam int SLOT_BITS    = 32;
  localparam int FB           = 2 * SLOT_BITS;
  localparam int FRAME_CYCLES = FB * 2 * CLK_DIV;

  typedef struct {
    logic [FB-1:0] sd;
    logic [FB-1:0] lr;
    logic          ur;
    int            ov;
    int            fs_extra;
    int            ur_extra;
  } frame_t;

  logic   clock = 1'b0;
  logic   reset;
  int     errors = 0;
  int     checks = 0;
  frame_t cap_q[$];
  frame_t exp_q[$];

  audio_serial_tx_if aif ();

  audio_serial_tx #(
    .CLK_DIV   (CLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (aif.slave)
  );

  always #5 clock = ~clock;

  initial begin : watchdog
    #(300_000);
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Expected frame: each sample MSB-first at the top of its slot, zero padding below.
  function automatic frame_t make_frame(input logic [17:0] l, input logic [17:0] r,
                                        input logic ur, input int ov);
    frame_t f;
    f.sd = '0;
    f.lr = '0;
    for (int i = 0; i < 18; i++) begin
      f.sd[FB-1-i]        = l[17-i];
      f.sd[SLOT_BITS-1-i] = r[17-i];
    end
    for (int i = 0; i < SLOT_BITS; i++) f.lr[i] = 1'b1;
    f.ur       = ur;
    f.ov       = ov;
    f.fs_extra = 0;
    f.ur_extra = 0;
    return f;
  endfunction

  // Records every complete frame, starting at the frame_start cycle (bit 0).
  initial begin : monitor
    frame_t cur;
    bit     active;
    int     nbits;
    logic   prev_sclk;
    active    = 1'b0;
    nbits     = 0;
    prev_sclk = 1'b0;
    cur       = make_frame('0, '0, 1'b0, 0);
    forever begin
      @(negedge clock);
      if (reset !== 1'b1) begin
        active = 1'b0;
      end else if (!active) begin
        if (aif.frame_start === 1'b1) begin
          cur            = make_frame('0, '0, 1'b0, 0);
          cur.lr         = '0;
          cur.sd[FB-1]   = aif.sdata;
          cur.lr[FB-1]   = aif.lrclk;
          cur.ur         = aif.underrun;
          cur.ov         = (aif.overrun === 1'b1) ? 1 : 0;
          nbits          = 1;
          active         = 1'b1;
        end
      end else begin
        if (aif.frame_start === 1'b1) cur.fs_extra++;
        if (aif.underrun === 1'b1)    cur.ur_extra++;
        if (aif.overrun === 1'b1)     cur.ov++;
        if (prev_sclk === 1'b1 && aif.sclk === 1'b0) begin
          cur.sd[FB-1-nbits] = aif.sdata;
          cur.lr[FB-1-nbits] = aif.lrclk;
          nbits++;
          if (nbits == FB) begin
            cap_q.push_back(cur);
            active = 1'b0;
          end
        end
      end
      prev_sclk = aif.sclk;
    end
  end

  task automatic pulse_ready(input logic [17:0] l, input logic [17:0] r);
    aif.l_audio_in = l;
    aif.r_audio_in = r;
    aif.ready      = 1'b1;
    @(posedge clock);
    #1;
    aif.ready      = 1'b0;
  endtask

  task automatic sync_frame_start();
    int n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (aif.frame_start !== 1'b1 && n < 2 * FRAME_CYCLES);
    if (aif.frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL sync_frame_start: no frame_start within %0d cycles", n);
    end
  endtask

  task automatic next_frame(output frame_t got, output frame_t exp);
    int n = 0;
    while (cap_q.size() == 0 && n < 2 * FRAME_CYCLES) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (cap_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL next_frame: no frame captured within %0d cycles", n);
      got = make_frame('x, 'x, 1'bx, -1);
    end else begin
      got = cap_q.pop_front();
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL next_frame: no expected frame queued");
      exp = make_frame('0, '0, 1'b0, 0);
    end else begin
      exp = exp_q.pop_front();
    end
  endtask

  task automatic observe_restart(output logic [4:0] sh, output logic [4:0] fh,
                                 output logic [4:0] uh, output logic [4:0] oh);
    for (int k = 0; k < 5; k++) begin
      sh[k] = aif.sclk;
      fh[k] = aif.frame_start;
      uh[k] = aif.underrun;
      oh[k] = aif.overrun;
      if (k < 4) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] sh, fh, uh, oh;
    logic [5:0] outs;
    reset          = 1'b0;
    aif.ready      = 1'b0;
    aif.l_audio_in = '0;
    aif.r_audio_in = '0;
    repeat (3) @(posedge clock);
    #1;
    outs = {aif.sclk, aif.lrclk, aif.sdata, aif.frame_start, aif.underrun, aif.overrun};
    checks++;
    if (outs !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b exp 000000", outs);
    end
    reset = 1'b1;
    observe_restart(sh, fh, uh, oh);
    checks++;
    if (sh !== 5'b01100) begin errors++; $display("FAIL reset_sclk_seq: got %b exp 01100", sh); end
    checks++;
    if (fh !== 5'b10000) begin errors++; $display("FAIL reset_frame_start_seq: got %b exp 10000", fh); end
    checks++;
    if (uh !== 5'b10000) begin errors++; $display("FAIL reset_underrun_seq: got %b exp 10000", uh); end
    checks++;
    if (oh !== 5'b00000) begin errors++; $display("FAIL reset_overrun_seq: got %b exp 00000", oh); end
    exp_q.push_back(make_frame('0, '0, 1'b1, 0));
  endtask

  task automatic test_underrun();
    frame_t got, exp;
    next_frame(got, exp);
    checks++;
    if (got.sd !== exp.sd) begin errors++; $display("FAIL underrun_sdata: got %h exp %h", got.sd, exp.sd); end
    checks++;
    if (got.lr !== exp.lr) begin errors++; $display("FAIL underrun_lrclk: got %h exp %h", got.lr, exp.lr); end
    checks++;
    if (got.ur !== exp.ur) begin errors++; $display("FAIL underrun_flag: got %b exp %b", got.ur, exp.ur); end
    checks++;
    if (got.fs_extra != exp.fs_extra || got.ur_extra != exp.ur_extra) begin
      errors++;
      $display("FAIL underrun_pulse_width: got extra fs=%0d ur=%0d exp 0 0", got.fs_extra, got.ur_extra);
    end
  endtask

  task automatic test_alternating();
    frame_t got, exp;
    exp_q.push_back(make_frame(18'h2AAAA, 18'h15555, 1'b0, 0));
    pulse_ready(18'h2AAAA, 18'h15555);
    next_frame(got, exp);
    checks++;
    if (got.sd !== exp.sd) begin errors++; $display("FAIL alt_sdata: got %h exp %h", got.sd, exp.sd); end
    checks++;
    if (got.lr !== exp.lr) begin errors++; $display("FAIL alt_lrclk: got %h exp %h", got.lr, exp.lr); end
    checks++;
    if (got.ur !== exp.ur || got.ur_extra != 0) begin
      errors++;
      $display("FAIL alt_underrun: got %b/%0d exp %b/0", got.ur, got.ur_extra, exp.ur);
    end
  endtask

  task automatic test_overrun();
    frame_t got, exp;
    exp_q.push_back(make_frame('0, '0, 1'b1, 1));
    exp_q.push_back(make_frame(18'h3C3C3, 18'h0ABCD, 1'b0, 0));
    sync_frame_start();
    pulse_ready(18'h0F0F0, 18'h12345);
    repeat (10) @(posedge clock);
    #1;
    pulse_ready(18'h3C3C3, 18'h0ABCD);
    next_frame(got, exp);
    checks++;
    if (got.ov !== exp.ov) begin errors++; $display("FAIL ovr_count: got %0d exp %0d", got.ov, exp.ov); end
    checks++;
    if (got.sd !== exp.sd || got.ur !== exp.ur) begin
      errors++;
      $display("FAIL ovr_current_frame: got %h/%b exp %h/%b", got.sd, got.ur, exp.sd, exp.ur);
    end
    next_frame(got, exp);
    checks++;
    if (got.sd !== exp.sd) begin errors++; $display("FAIL ovr_newest_wins: got %h exp %h", got.sd, exp.sd); end
    checks++;
    if (got.ov !== exp.ov || got.ur !== exp.ur) begin
      errors++;
      $display("FAIL ovr_next_flags: got ov=%0d ur=%b exp ov=%0d ur=%b", got.ov, got.ur, exp.ov, exp.ur);
    end
  endtask

  task automatic test_coincident();
    frame_t got, exp;
    exp_q.push_back(make_frame('0, '0, 1'b1, 0));
    exp_q.push_back(make_frame('0, '0, 1'b1, 0));
    exp_q.push_back(make_frame(18'h00001, 18'h20000, 1'b0, 0));
    sync_frame_start();
    repeat (FRAME_CYCLES - 1) @(posedge clock);
    #1;
    pulse_ready(18'h00001, 18'h20000);
    for (int f = 0; f < 3; f++) begin
      next_frame(got, exp);
      checks++;
      if (got.sd !== exp.sd || got.ur !== exp.ur || got.ov !== exp.ov) begin
        errors++;
        $display("FAIL coinc_frame%0d: got %h ur=%b ov=%0d exp %h ur=%b ov=%0d",
                 f, got.sd, got.ur, got.ov, exp.sd, exp.ur, exp.ov);
      end
    end
    checks++;
    if (got.sd[FB-1-17] !== 1'b1) begin
      errors++;
      $display("FAIL coinc_left_pos17: got %b exp 1", got.sd[FB-1-17]);
    end
  endtask

  task automatic test_back_to_back();
    frame_t got, exp;
    exp_q.push_back(make_frame('0, '0, 1'b1, 0));
    exp_q.push_back(make_frame(18'h11111, 18'h22222, 1'b0, 0));
    exp_q.push_back(make_frame(18'h33333, 18'h04444, 1'b0, 0));
    sync_frame_start();
    repeat (10) @(posedge clock);
    #1;
    pulse_ready(18'h11111, 18'h22222);
    repeat (FRAME_CYCLES - 12) @(posedge clock);
    #1;
    pulse_ready(18'h33333, 18'h04444);
    for (int f = 0; f < 3; f++) begin
      next_frame(got, exp);
      checks++;
      if (got.sd !== exp.sd || got.ur !== exp.ur || got.ov !== exp.ov) begin
        errors++;
        $display("FAIL b2b_frame%0d: got %h ur=%b ov=%0d exp %h ur=%b ov=%0d",
                 f, got.sd, got.ur, got.ov, exp.sd, exp.ur, exp.ov);
      end
    end
  endtask

  task automatic test_mid_reset();
    frame_t     got, exp;
    logic [4:0] sh, fh, uh, oh;
    logic [5:0] outs;
    sync_frame_start();
    repeat (20) @(posedge clock);
    #1;
    pulse_ready(18'h3FFFF, 18'h3FFFF);
    // Cycle 161 of the frame lies inside bit index 40.
    repeat (140) @(posedge clock);
    #1;
    checks++;
    if (aif.lrclk !== 1'b1) begin errors++; $display("FAIL midrst_lrclk_before: got %b exp 1", aif.lrclk); end
    reset = 1'b0;
    @(posedge clock);
    #1;
    outs = {aif.sclk, aif.lrclk, aif.sdata, aif.frame_start, aif.underrun, aif.overrun};
    checks++;
    if (outs !== 6'b0) begin errors++; $display("FAIL midrst_outputs: got %b exp 000000", outs); end
    reset = 1'b1;
    observe_restart(sh, fh, uh, oh);
    checks++;
    if (sh !== 5'b01100) begin errors++; $display("FAIL midrst_sclk_seq: got %b exp 01100", sh); end
    checks++;
    if (fh !== 5'b10000 || oh !== 5'b00000) begin
      errors++;
      $display("FAIL midrst_fs_ov_seq: got fs=%b ov=%b exp fs=10000 ov=00000", fh, oh);
    end
    exp_q.push_back(make_frame('0, '0, 1'b1, 0));
    next_frame(got, exp);
    checks++;
    if (got.sd !== exp.sd || got.ur !== exp.ur || got.ov !== exp.ov) begin
      errors++;
      $display("FAIL midrst_held_discarded: got %h ur=%b ov=%0d exp %h ur=%b ov=%0d",
               got.sd, got.ur, got.ov, exp.sd, exp.ur, exp.ov);
    end
  endtask

  initial begin : main
    test_reset();
    test_underrun();
    test_alternating();
    test_overrun();
    test_coincident();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/audio_serial_tx.md
AUDIO_SERIAL_TX -- requirements
Module: audio_serial_tx

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 4: system clocks per sclk half-period; legal range 1 or more.
REQ-002 The module SHALL have parameter SLOT_BITS, default 32: sclk periods per channel slot; legal range 18 or more.
REQ-003 The module SHALL have these ports, with one clock and a synchronous, active-low reset:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- l_audio_in  in  18  left sample, two's complement.
- r_audio_in  in  18  right sample, two's complement.
- ready  in  1  one-cycle strobe; l_audio_in and r_audio_in are valid in the same cycle.
- sclk  out  1  serial bit clock.
- lrclk  out  1  channel select: 0 = left slot, 1 = right slot.
- sdata  out  1  serial data, MSB first.
- frame_start  out  1  one-cycle pulse at each frame boundary.
- underrun  out  1  one-cycle pulse: the frame was loaded with zeros.
- overrun  out  1  one-cycle pulse: an unsent held sample was overwritten.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 Divider counter SHALL count 0..CLK_DIV-1 and wrap. In the cycle it equals CLK_DIV-1, sclk SHALL toggle on the next edge.
REQ-006 A bit tick SHALL be a toggle that drives sclk from 1 to 0. sdata and lrclk SHALL change only on bit ticks, so a receiver samples on the sclk rising edge.
REQ-007 Bit index SHALL run 0..2*SLOT_BITS-1 and advance by one per bit tick. It SHALL wrap to 0 after 2*SLOT_BITS-1; that wrap is the frame boundary.
REQ-008 lrclk SHALL be 0 for bit index 0..SLOT_BITS-1 and 1 for SLOT_BITS..2*SLOT_BITS-1.
REQ-009 Within each slot, sdata SHALL carry sample bits 17..0 at slot positions 0..17 (left-justified, no one-bit delay). Positions 18..SLOT_BITS-1 SHALL be 0.
REQ-010 The holding register SHALL hold one {L,R} pair plus a full flag. On ready it SHALL capture l_audio_in and r_audio_in and set full.
REQ-011 ready while full=1 and not at a load SHALL overwrite the held pair (newest wins) and pulse overrun in the following cycle.
REQ-012 At a frame boundary with full=1, the shift register SHALL load the held pair and clear full.
REQ-013 At a frame boundary with full=0, the shift register SHALL load all zeros and underrun SHALL pulse.
REQ-014 frame_start SHALL pulse for exactly the cycle in which sdata first presents left bit 17 (bit index 0).
REQ-015 underrun SHALL pulse in the same cycle as the frame_start of the affected frame.
REQ-016 Simultaneous ready and frame boundary with full=1 SHALL transmit the old pair, capture the new pair, and leave full=1, with no overrun.
REQ-017 Simultaneous ready and frame boundary with full=0 SHALL transmit zeros and pulse underrun. The new pair SHALL be captured, full SHALL set, and the pair SHALL be sent in the next frame.
REQ-018 Latency SHALL be bounded: a pair captured while full=0 SHALL begin transmission at the next frame boundary.

Reset
REQ-019 While reset=0 at a rising edge, the block SHALL set on the next cycle: sclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, overrun=0, divider=0, bit index=2*SLOT_BITS-1, full=0, shift register=0.
REQ-020 After reset release, the first bit tick SHALL occur 2*CLK_DIV cycles later and SHALL be a frame boundary.
REQ-021 Reset asserted mid-frame SHALL abort the frame and discard the held pair. No underrun or overrun pulse SHALL be generated by the reset itself.

Verification (CLK_DIV=2, SLOT_BITS=32)
REQ-022 The bench SHALL cover these scenarios:
- reset=0 for 3 cycles, then released -> all outputs 0; sclk rises at cycle 2; first falling edge and frame_start at cycle 4.
- ready with L=18'h2AAAA, R=18'h15555 before the first boundary -> left slot carries 101010... for 18 bits then 14 zeros with lrclk=0; right slot carries 010101... for 18 bits then 14 zeros with lrclk=1; underrun never pulses.
- no ready before a boundary -> 64 zero bits; underrun and frame_start high together for one cycle.
- two ready pulses in one frame (pair A, then pair B) -> overrun pulses once; the next frame carries B.
- ready coincident with a boundary, full=0, L=18'h00001 -> that frame is zeros with underrun; the next frame has left slot bit position 17 = 1.
- reset=0 at bit index 40 -> next cycle all outputs 0 and full=0; the restart obeys REQ-020.
